// File: rtl/miner_pkg.sv
// Shared widths and controller state encoding for the nonce search block.
package miner_pkg;
   localparam int HEADER_W = 640;
   localparam int PREFIX_W = 608;
   localparam int NONCE_W  = 32;
   localparam int DIGEST_W = 256;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      CHECK,
      FIN
   } state_e;
endpackage

// File: rtl/nonce_search_ctrl_if.sv
// Host and sha256-core facing signals of the nonce search controller.
interface nonce_search_ctrl_if;
   logic                           start;
   logic                           stop;
   logic [miner_pkg::PREFIX_W-1:0] header_prefix;
   logic [miner_pkg::NONCE_W-1:0]  nonce_start;
   logic [miner_pkg::NONCE_W-1:0]  nonce_end;
   logic [miner_pkg::DIGEST_W-1:0] target;
   logic                           core_rst;
   logic [miner_pkg::HEADER_W-1:0] core_header;
   logic [miner_pkg::DIGEST_W-1:0] core_digest;
   logic                           busy;
   logic                           done;
   logic                           found;
   logic                           exhausted;
   logic [miner_pkg::NONCE_W-1:0]  found_nonce;
   logic [miner_pkg::DIGEST_W-1:0] found_digest;

   modport master (
      output start, stop, header_prefix, nonce_start, nonce_end, target, core_digest,
      input  core_rst, core_header, busy, done, found, exhausted, found_nonce, found_digest
   );

   modport slave (
      input  start, stop, header_prefix, nonce_start, nonce_end, target, core_digest,
      output core_rst, core_header, busy, done, found, exhausted, found_nonce, found_digest
   );
endinterface

// File: rtl/digest_le_target.sv
// Combinational unsigned digest <= target compare; kept separate so a pipelined
// comparator can replace it without touching the controller.
module digest_le_target
   import miner_pkg::*;
(
   input  logic [DIGEST_W-1:0] digest,
   input  logic [DIGEST_W-1:0] target,
   output logic                le
);
   assign le = (digest <= target);
endmodule

// File: rtl/nonce_search_ctrl.sv
// Sweeps an inclusive nonce range through the sha256 core, HASH_LATENCY+2 cycles per nonce,
// stopping at the first digest <= target; start is ignored while busy, stop aborts any sweep.
module nonce_search_ctrl
   import miner_pkg::*;
#(
   parameter int HASH_LATENCY = 4
) (
   input  logic                clk,
   input  logic                reset,
   nonce_search_ctrl_if.slave  bus
);
   localparam int               CNT_W    = $clog2(HASH_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HASH_LATENCY - 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NONCE_W-1:0]  nonce_q, nonce_d;
   logic [NONCE_W-1:0]  nonce_end_q, nonce_end_d;
   logic [PREFIX_W-1:0] prefix_q, prefix_d;
   logic [DIGEST_W-1:0] target_q, target_d;
   logic [NONCE_W-1:0]  found_nonce_q, found_nonce_d;
   logic [DIGEST_W-1:0] found_digest_q, found_digest_d;
   logic                core_rst_q, core_rst_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                found_q, found_d;
   logic                exhausted_q, exhausted_d;
   logic                hit;

   digest_le_target u_cmp (
      .digest (bus.core_digest),
      .target (target_q),
      .le     (hit)
   );

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      nonce_d        = nonce_q;
      nonce_end_d    = nonce_end_q;
      prefix_d       = prefix_q;
      target_d       = target_q;
      found_nonce_d  = found_nonce_q;
      found_digest_d = found_digest_q;
      busy_d         = busy_q;
      found_d        = found_q;
      exhausted_d    = exhausted_q;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               prefix_d    = bus.header_prefix;
               target_d    = bus.target;
               nonce_end_d = bus.nonce_end;
               nonce_d     = bus.nonce_start;
               found_d     = 1'b0;
               exhausted_d = 1'b0;
               busy_d      = 1'b1;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = bus.stop ? FIN : RUN;
         end
         RUN: begin
            if (bus.stop) begin
               state_d = FIN;
            end else if (cnt_q == CNT_LAST) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CHECK: begin
            // A hit is recorded even when stop arrives in the same cycle.
            if (hit) begin
               found_d        = 1'b1;
               found_nonce_d  = nonce_q;
               found_digest_d = bus.core_digest;
               state_d        = FIN;
            end else if (bus.stop) begin
               state_d = FIN;
            end else if (nonce_q == nonce_end_q) begin
               exhausted_d = 1'b1;
               state_d     = FIN;
            end else begin
               nonce_d = nonce_q + 1'b1;
               state_d = LOAD;
            end
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Derived from the next state so the registered outputs line up with state_q.
      core_rst_d = !((state_d == RUN) || (state_d == CHECK));
      done_d     = (state_d == FIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         nonce_q        <= '0;
         nonce_end_q    <= '0;
         prefix_q       <= '0;
         target_q       <= '0;
         found_nonce_q  <= '0;
         found_digest_q <= '0;
         core_rst_q     <= 1'b1;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         found_q        <= 1'b0;
         exhausted_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         nonce_q        <= nonce_d;
         nonce_end_q    <= nonce_end_d;
         prefix_q       <= prefix_d;
         target_q       <= target_d;
         found_nonce_q  <= found_nonce_d;
         found_digest_q <= found_digest_d;
         core_rst_q     <= core_rst_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         found_q        <= found_d;
         exhausted_q    <= exhausted_d;
      end
   end

   assign bus.core_rst     = core_rst_q;
   assign bus.core_header  = {nonce_q, prefix_q};
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.found        = found_q;
   assign bus.exhausted    = exhausted_q;
   assign bus.found_nonce  = found_nonce_q;
   assign bus.found_digest = found_digest_q;
endmodule
